// File: rtl/mem_stream_writer_pkg.sv
// Shared types and helpers for the memory-path stream writer.
// Holds the frame FSM encoding and the frame-length clamp.
package mem_stream_writer_pkg;

  localparam int unsigned MSW_WIDTH_DEF = 4;
  localparam int unsigned MSW_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } msw_state_t;

  // A frame can never be longer than the memory it lands in.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/mem_stream_writer_if.sv
// Stream-in / memory-write-out bundle for mem_stream_writer.
// master drives the stream and control; slave is the writer block.
interface mem_stream_writer_if
  import mem_stream_writer_pkg::*;
#(
  parameter int unsigned width_p = MSW_WIDTH_DEF,
  parameter int unsigned depth_p = MSW_DEPTH_DEF
);
  localparam int unsigned aw_lp = $clog2(depth_p);
  localparam int unsigned cw_lp = $clog2(depth_p + 1);

  logic               start_i;
  logic [cw_lp-1:0]   length_i;
  logic               valid_i;
  logic               ready_o;
  logic [width_p-1:0] data_i;
  logic               wr_e_o;
  logic [aw_lp-1:0]   wr_addr_o;
  logic [width_p-1:0] wr_data_o;
  logic               busy_o;
  logic               done_o;
  logic [cw_lp-1:0]   count_o;

  modport master (
    output start_i, length_i, valid_i, data_i,
    input  ready_o, wr_e_o, wr_addr_o, wr_data_o, busy_o, done_o, count_o
  );

  modport slave (
    input  start_i, length_i, valid_i, data_i,
    output ready_o, wr_e_o, wr_addr_o, wr_data_o, busy_o, done_o, count_o
  );

endinterface

// File: rtl/mem_stream_writer_wr_port_reg.sv
// Registered memory write port: one-cycle stage for wr_e/addr/data.
// Latency 1; no backpressure; address/data hold when no write is loaded.
module mem_stream_writer_wr_port_reg #(
  parameter int unsigned width_p  = 4,
  parameter int unsigned addr_w_p = 2
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                load_i,
  input  logic [addr_w_p-1:0] addr_i,
  input  logic [width_p-1:0]  data_i,
  output logic                wr_e_o,
  output logic [addr_w_p-1:0] wr_addr_o,
  output logic [width_p-1:0]  wr_data_o
);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_e_o    <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_e_o <= load_i;
      if (load_i) begin
        wr_addr_o <= addr_i;
        wr_data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/mem_stream_writer.sv
// Writes a framed valid/ready stream into consecutive memory words.
// Write issues 1 cycle after acceptance; ready_o depends only on state/count.
module mem_stream_writer
  import mem_stream_writer_pkg::*;
#(
  parameter int unsigned width_p = MSW_WIDTH_DEF,
  parameter int unsigned depth_p = MSW_DEPTH_DEF
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  mem_stream_writer_if.slave bus
);

  localparam int unsigned aw_lp = $clog2(depth_p);
  localparam int unsigned cw_lp = $clog2(depth_p + 1);
  localparam logic [aw_lp-1:0] addr_last_lp = aw_lp'(depth_p - 1);

  msw_state_t       state_q, state_d;
  logic [cw_lp-1:0] cnt_q;
  logic [cw_lp-1:0] len_q;
  logic [aw_lp-1:0] addr_q;
  logic [cw_lp-1:0] len_clamped;
  logic             start_ok;
  logic             accept;
  logic             last_word;

  assign len_clamped = cw_lp'(clamp_len(32'(bus.length_i), depth_p));
  assign start_ok    = bus.start_i && (state_q != ST_WRITE);
  assign bus.ready_o = (state_q == ST_WRITE) && (cnt_q < len_q);
  assign accept      = bus.valid_i && bus.ready_o;
  assign last_word   = ((cnt_q + cw_lp'(1)) == len_q);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // An empty frame skips WRITE so done_o rises on the next cycle.
        if (bus.start_i) state_d = (len_clamped == '0) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        if (accept && last_word) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      len_q  <= '0;
      addr_q <= '0;
    end else if (start_ok) begin
      cnt_q  <= '0;
      len_q  <= len_clamped;
      addr_q <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_q + cw_lp'(1);
      addr_q <= (addr_q == addr_last_lp) ? '0 : addr_q + aw_lp'(1);
    end
  end

  mem_stream_writer_wr_port_reg #(
    .width_p  (width_p),
    .addr_w_p (aw_lp)
  ) u_wr_port_reg (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .load_i    (accept),
    .addr_i    (addr_q),
    .data_i    (bus.data_i),
    .wr_e_o    (bus.wr_e_o),
    .wr_addr_o (bus.wr_addr_o),
    .wr_data_o (bus.wr_data_o)
  );

  assign bus.busy_o  = (state_q == ST_WRITE);
  assign bus.done_o  = (state_q == ST_DONE);
  assign bus.count_o = cnt_q;

endmodule

// File: tb/tb_mem_stream_writer.sv
// Bench for mem_stream_writer: directed vector table, reset corner, random run.
module tb_mem_stream_writer;

  localparam int W = 4;
  localparam int D = 4;

  logic clk_i;
  logic reset_ni;

  mem_stream_writer_if #(.width_p(W), .depth_p(D)) bus ();

  mem_stream_writer #(.width_p(W), .depth_p(D)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame phase 0=idle, 1=writing, 2=done.
  int m_phase, m_len, m_nacc, m_we, m_wa, m_wd;

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_nacc = 0;
    m_we = 0; m_wa = 0; m_wd = 0;
  endtask

  function automatic int m_ready();
    return (m_phase == 1 && m_nacc < m_len) ? 1 : 0;
  endfunction

  task automatic model_edge(input int s, input int l, input int v, input int d);
    int acc;
    acc = (v != 0 && m_ready() != 0) ? 1 : 0;
    m_we = acc;
    if (acc != 0) begin
      m_wa = m_nacc % D;
      m_wd = d % 16;
    end
    if (m_phase != 1 && s != 0) begin
      m_len  = (l > D) ? D : l;
      m_nacc = 0;
      m_phase = (m_len == 0) ? 2 : 1;
    end else if (acc != 0) begin
      m_nacc++;
      if (m_nacc == m_len) m_phase = 2;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " ready"},  int'(bus.ready_o),   m_ready());
    chk({tag, " wr_e"},   int'(bus.wr_e_o),    m_we);
    chk({tag, " addr"},   int'(bus.wr_addr_o), m_wa);
    chk({tag, " wdata"},  int'(bus.wr_data_o), m_wd);
    chk({tag, " busy"},   int'(bus.busy_o),    (m_phase == 1) ? 1 : 0);
    chk({tag, " done"},   int'(bus.done_o),    (m_phase == 2) ? 1 : 0);
    chk({tag, " count"},  int'(bus.count_o),   m_nacc);
  endtask

  // Called at a negedge: drive inputs, let combinational outputs settle, compare.
  int cur_s, cur_l, cur_v, cur_d;
  task automatic drive(input int s, input int l, input int v, input int d, input string tag);
    cur_s = s; cur_l = l; cur_v = v; cur_d = d;
    bus.start_i  = s[0];
    bus.length_i = 3'(l);
    bus.valid_i  = v[0];
    bus.data_i   = 4'(d);
    #1;
    check_model(tag);
  endtask

  task automatic step();
    model_edge(cur_s, cur_l, cur_v, cur_d);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " ready"}, int'(bus.ready_o),   0);
    chk({tag, " wr_e"},  int'(bus.wr_e_o),    0);
    chk({tag, " addr"},  int'(bus.wr_addr_o), 0);
    chk({tag, " wdata"}, int'(bus.wr_data_o), 0);
    chk({tag, " busy"},  int'(bus.busy_o),    0);
    chk({tag, " done"},  int'(bus.done_o),    0);
    chk({tag, " count"}, int'(bus.count_o),   0);
  endtask

  typedef struct {
    int s, l, v, d;
    int rdy, we, wa, wd, busy, done, cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    // inputs this cycle | outputs observed this cycle (before the edge)
    vecs[0]  = '{1,4,0,0,  0,0,0,0, 0,0,0};
    vecs[1]  = '{0,0,1,1,  1,0,0,0, 1,0,0};
    vecs[2]  = '{0,0,1,2,  1,1,0,1, 1,0,1};
    vecs[3]  = '{0,0,1,3,  1,1,1,2, 1,0,2};
    vecs[4]  = '{0,0,1,4,  1,1,2,3, 1,0,3};
    vecs[5]  = '{0,0,1,9,  0,1,3,4, 0,1,4};
    vecs[6]  = '{0,0,0,0,  0,0,3,4, 0,1,4};
    vecs[7]  = '{1,3,0,0,  0,0,3,4, 0,1,4};
    vecs[8]  = '{0,0,1,5,  1,0,3,4, 1,0,0};
    vecs[9]  = '{0,0,0,6,  1,1,0,5, 1,0,1};
    vecs[10] = '{0,0,1,7,  1,0,0,5, 1,0,1};
    vecs[11] = '{0,0,0,8,  1,1,1,7, 1,0,2};
    vecs[12] = '{0,0,1,10, 1,0,1,7, 1,0,2};
    vecs[13] = '{0,0,0,0,  0,1,2,10,0,1,3};
    vecs[14] = '{0,0,1,11, 0,0,2,10,0,1,3};
    vecs[15] = '{1,0,0,0,  0,0,2,10,0,1,3};
    vecs[16] = '{0,0,1,12, 0,0,2,10,0,1,0};
    vecs[17] = '{0,0,1,13, 0,0,2,10,0,1,0};
    vecs[18] = '{1,7,1,14, 0,0,2,10,0,1,0};
    vecs[19] = '{1,2,1,1,  1,0,2,10,1,0,0};
    vecs[20] = '{0,0,1,2,  1,1,0,1, 1,0,1};
    vecs[21] = '{0,0,1,3,  1,1,1,2, 1,0,2};
    vecs[22] = '{0,0,1,4,  1,1,2,3, 1,0,3};
    vecs[23] = '{0,0,1,5,  0,1,3,4, 0,1,4};
    vecs[24] = '{0,0,1,6,  0,0,3,4, 0,1,4};

    reset_ni     = 1'b0;
    bus.start_i  = 1'b0;
    bus.length_i = '0;
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    model_reset();
    #1;
    all_zero("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vecs[i].s, vecs[i].l, vecs[i].v, vecs[i].d, t);
      chk({t, " tbl_ready"}, int'(bus.ready_o),   vecs[i].rdy);
      chk({t, " tbl_wr_e"},  int'(bus.wr_e_o),    vecs[i].we);
      chk({t, " tbl_addr"},  int'(bus.wr_addr_o), vecs[i].wa);
      chk({t, " tbl_wdata"}, int'(bus.wr_data_o), vecs[i].wd);
      chk({t, " tbl_busy"},  int'(bus.busy_o),    vecs[i].busy);
      chk({t, " tbl_done"},  int'(bus.done_o),    vecs[i].done);
      chk({t, " tbl_count"}, int'(bus.count_o),   vecs[i].cnt);
      step();
    end

    // Reset with a write pending after 2 of 4 words.
    drive(1, 4, 0, 0, "rst0"); step();
    drive(0, 0, 1, 1, "rst1"); step();
    drive(0, 0, 1, 2, "rst2"); step();
    drive(0, 0, 1, 3, "rst3");
    chk("rst pending wr_e", int'(bus.wr_e_o), 1);
    reset_ni = 1'b0;
    #1;
    all_zero("midframe_reset");
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 5 + i, "post_rst_idle"); step();
    end
    drive(1, 2, 0, 0, "restart0"); step();
    drive(0, 0, 1, 6, "restart1"); step();
    drive(0, 0, 1, 7, "restart2");
    chk("restart first addr", int'(bus.wr_addr_o), 0);
    chk("restart first data", int'(bus.wr_data_o), 6);
    step();
    drive(0, 0, 0, 0, "restart3"); step();

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_ni = 1'b0;
        model_reset();
        #1;
        check_model("rand_reset");
        @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
      end else begin
        drive(($urandom_range(0, 7) == 0) ? 1 : 0,
              int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) != 0) ? 1 : 0,
              int'($urandom_range(0, 15)),
              "rand");
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
